// File: rtl/regfile_pkg.sv
// Shared register-file constants for the operand-fetch stage and its scoreboard.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_REGBITS = 5;
  localparam int unsigned NUM_REGS    = 1 << DEF_REGBITS;
  // r0 reads as zero and is never tracked as busy.
  localparam int unsigned REG_ZERO    = 0;

  // Register count for an arbitrary address width.
  function automatic int unsigned num_regs(input int unsigned bits);
    return 1 << bits;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, with two hazard queries
// that already account for a writeback landing in the current cycle.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned REGBITS = DEF_REGBITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               set_en,
  input  logic [REGBITS-1:0] set_addr,
  input  logic               clr_en,
  input  logic [REGBITS-1:0] clr_addr,
  input  logic [REGBITS-1:0] q1_addr,
  input  logic [REGBITS-1:0] q2_addr,
  output logic               q1_hazard,
  output logic               q2_hazard
);

  localparam int unsigned N = num_regs(REGBITS);
  localparam logic [REGBITS-1:0] Zero = REGBITS'(REG_ZERO);

  logic [N-1:0] busy_q, busy_d;

  // Next busy vector: clear from writeback first, then set from issue so set wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (clr_en) busy_d[clr_addr] = 1'b0;
      if (set_en && (set_addr != Zero)) busy_d[set_addr] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // A writeback to the queried register this cycle resolves the hazard via bypass.
  assign q1_hazard = (q1_addr != Zero) && busy_q[q1_addr] && !(clr_en && (clr_addr == q1_addr));
  assign q2_hazard = (q2_addr != Zero) && busy_q[q2_addr] && !(clr_en && (clr_addr == q2_addr));

endmodule

// File: rtl/regread_stage.sv
// Operand-fetch stage: regfile read, writeback bypass, hazard stall and a
// single registered output entry toward execute.
module regread_stage
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned REGBITS = DEF_REGBITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [REGBITS-1:0] in_rs,
  input  logic [REGBITS-1:0] in_rt,
  input  logic [REGBITS-1:0] in_rd,
  input  logic               in_wen,
  output logic [REGBITS-1:0] ra1,
  output logic [REGBITS-1:0] ra2,
  input  logic [WIDTH-1:0]   rd1,
  input  logic [WIDTH-1:0]   rd2,
  input  logic               wb_en,
  input  logic [REGBITS-1:0] wb_addr,
  input  logic [WIDTH-1:0]   wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic [REGBITS-1:0] out_rd,
  output logic               out_wen
);

  localparam logic [REGBITS-1:0] Zero = REGBITS'(REG_ZERO);

  logic               haz_rs, haz_rt;
  logic               accept;
  logic [WIDTH-1:0]   op_a, op_b;

  logic               out_valid_q;
  logic [WIDTH-1:0]   out_a_q, out_b_q;
  logic [REGBITS-1:0] out_rd_q;
  logic               out_wen_q;

  assign ra1 = in_rs;
  assign ra2 = in_rt;

  reg_scoreboard #(
    .REGBITS (REGBITS)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .set_en    (accept && in_wen),
    .set_addr  (in_rd),
    .clr_en    (wb_en),
    .clr_addr  (wb_addr),
    .q1_addr   (in_rs),
    .q2_addr   (in_rt),
    .q1_hazard (haz_rs),
    .q2_hazard (haz_rt)
  );

  assign in_ready = !flush && (!out_valid_q || out_ready) && !haz_rs && !haz_rt;
  assign accept   = in_valid && in_ready;

  // Operand select: r0 is zero, a same-cycle writeback overrides the stale regfile data.
  always_comb begin
    op_a = rd1;
    op_b = rd2;
    if (in_rs == Zero)                       op_a = '0;
    else if (wb_en && (wb_addr == in_rs))    op_a = wb_data;
    if (in_rt == Zero)                       op_b = '0;
    else if (wb_en && (wb_addr == in_rt))    op_b = wb_data;
  end

  // Output entry: load on accept, drop on consume or flush, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_rd_q    <= '0;
      out_wen_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_a_q     <= op_a;
      out_b_q     <= op_b;
      out_rd_q    <= in_rd;
      out_wen_q   <= in_wen;
    end else if (flush || out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_rd    = out_rd_q;
  assign out_wen   = out_wen_q;

endmodule

// File: tb/tb_regread_stage.sv
// Directed bench for regread_stage with a behavioural regfile and an output scoreboard.
module tb_regread_stage;

  localparam int W = 32;
  localparam int RB = 5;

  logic          clk, reset, flush;
  logic          in_valid, in_ready, in_wen;
  logic [RB-1:0] in_rs, in_rt, in_rd;
  logic [RB-1:0] ra1, ra2;
  logic [W-1:0]  rd1, rd2;
  logic          wb_en;
  logic [RB-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic          out_valid, out_ready, out_wen;
  logic [W-1:0]  out_a, out_b;
  logic [RB-1:0] out_rd;

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [RB-1:0] rd;
    logic          wen;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] regs [32];
  int           checks = 0;
  int           errors = 0;

  regread_stage #(
    .WIDTH   (W),
    .REGBITS (RB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_wen    (in_wen),
    .ra1       (ra1),
    .ra2       (ra2),
    .rd1       (rd1),
    .rd2       (rd2),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_rd    (out_rd),
    .out_wen   (out_wen)
  );

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_op(input logic [RB-1:0] r);
    if (r == 0) return '0;
    if (wb_en && (wb_addr == r)) return wb_data;
    return regs[r];
  endfunction

  task automatic drive(input logic v, input logic [RB-1:0] rs, input logic [RB-1:0] rt,
                       input logic [RB-1:0] rd, input logic wen);
    in_valid = v;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_wen   = wen;
  endtask

  task automatic wb(input logic en, input logic [RB-1:0] addr, input logic [W-1:0] data);
    wb_en   = en;
    wb_addr = addr;
    wb_data = data;
  endtask

  task automatic check_ready(input string tag, input logic exp);
    #1;
    chk(tag, {31'b0, in_ready}, {31'b0, exp});
  endtask

  // One clock: score the output transfer, record an accepted issue, then advance.
  task automatic tick();
    exp_t e;
    #2;
    if (out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_output observed=valid expected=empty_scoreboard");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_a", out_a, e.a);
        chk("out_b", out_b, e.b);
        chk("out_rd", {27'b0, out_rd}, {27'b0, e.rd});
        chk("out_wen", {31'b0, out_wen}, {31'b0, e.wen});
      end
    end
    if (in_valid && in_ready) begin
      e.a   = model_op(in_rs);
      e.b   = model_op(in_rt);
      e.rd  = in_rd;
      e.wen = in_wen;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (wb_en && (wb_addr != 0)) regs[wb_addr] = wb_data;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    regs[3]  = 32'h11;
    regs[5]  = 32'h1234;
    regs[7]  = 32'h70;
    regs[9]  = 32'h99;
    regs[10] = 32'hAA;

    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b0);
    wb(1'b0, 0, '0);
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_a", out_a, 32'h0);
    chk("rst_out_b", out_b, 32'h0);
    chk("rst_out_rd", {27'b0, out_rd}, 32'h0);
    chk("rst_out_wen", {31'b0, out_wen}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_ready("rst_in_ready", 1'b1);

    // Basic read: rs=3, rt=0.
    drive(1'b1, 3, 0, 1, 1'b0);
    check_ready("t1_ready", 1'b1);
    tick();
    drive(1'b0, 0, 0, 0, 1'b0);
    chk("t1_out_valid", {31'b0, out_valid}, 32'h1);
    chk("t1_out_a_direct", out_a, 32'h11);
    tick();
    chk("t1_drained", {31'b0, out_valid}, 32'h0);

    // Same-cycle bypass on a busy register.
    drive(1'b1, 0, 0, 5, 1'b1);
    tick();
    drive(1'b0, 0, 0, 0, 1'b0);
    tick();
    drive(1'b1, 5, 0, 2, 1'b0);
    wb(1'b1, 5, 32'hDEAD);
    check_ready("t2_bypass_ready", 1'b1);
    tick();
    wb(1'b0, 0, '0);
    drive(1'b0, 0, 0, 0, 1'b0);
    chk("t2_out_a_direct", out_a, 32'hDEAD);
    tick();

    // Hazard stall until the writeback arrives.
    drive(1'b1, 0, 0, 7, 1'b1);
    tick();
    drive(1'b1, 7, 0, 3, 1'b0);
    check_ready("t3_stall0", 1'b0);
    tick();
    check_ready("t3_stall1", 1'b0);
    tick();
    wb(1'b1, 7, 32'h7777);
    check_ready("t3_release", 1'b1);
    tick();
    wb(1'b0, 0, '0);
    drive(1'b0, 0, 0, 0, 1'b0);
    chk("t3_out_a_direct", out_a, 32'h7777);
    tick();

    // Backpressure: hold for three cycles, then stream.
    drive(1'b1, 3, 3, 4, 1'b0);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 3, 0, 6, 1'b0);
    for (int c = 0; c < 3; c++) begin
      check_ready("t4_bp_ready", 1'b0);
      chk("t4_bp_valid", {31'b0, out_valid}, 32'h1);
      chk("t4_bp_a", out_a, 32'h11);
      chk("t4_bp_b", out_b, 32'h11);
      chk("t4_bp_rd", {27'b0, out_rd}, 32'd4);
      tick();
    end
    out_ready = 1'b1;
    check_ready("t4_resume", 1'b1);
    tick();
    drive(1'b1, 0, 3, 8, 1'b0);
    check_ready("t4_stream", 1'b1);
    chk("t4_stream_valid", {31'b0, out_valid}, 32'h1);
    tick();
    drive(1'b0, 0, 0, 0, 1'b0);
    chk("t4_stream_valid2", {31'b0, out_valid}, 32'h1);
    tick();

    // Writes to r0 never create a hazard.
    drive(1'b1, 0, 0, 0, 1'b1);
    tick();
    drive(1'b1, 0, 0, 1, 1'b0);
    check_ready("t5_r0_ready", 1'b1);
    tick();
    drive(1'b0, 0, 0, 0, 1'b0);
    chk("t5_out_a", out_a, 32'h0);
    tick();

    // Flush with a held entry and busy r9.
    drive(1'b1, 0, 0, 9, 1'b1);
    tick();
    out_ready = 1'b0;
    flush = 1'b1;
    drive(1'b1, 9, 0, 12, 1'b0);
    check_ready("t6_flush_ready", 1'b0);
    tick();
    flush = 1'b0;
    sb.delete();
    chk("t6_flush_valid", {31'b0, out_valid}, 32'h0);
    chk("t6_flush_rd_hold", {27'b0, out_rd}, 32'd9);
    chk("t6_flush_wen_hold", {31'b0, out_wen}, 32'h1);
    out_ready = 1'b1;
    drive(1'b1, 9, 0, 10, 1'b1);
    check_ready("t6_after_flush", 1'b1);
    tick();

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    drive(1'b1, 10, 0, 11, 1'b0);
    check_ready("t6_stall", 1'b0);
    chk("t6_stall_valid", {31'b0, out_valid}, 32'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_out_valid", {31'b0, out_valid}, 32'h0);
    chk("ar_out_a", out_a, 32'h0);
    chk("ar_out_b", out_b, 32'h0);
    chk("ar_out_rd", {27'b0, out_rd}, 32'h0);
    chk("ar_out_wen", {31'b0, out_wen}, 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    check_ready("ar_busy_cleared", 1'b1);
    tick();
    drive(1'b0, 0, 0, 0, 1'b0);
    tick();

    chk("sb_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
